// File: rtl/count_disp_pkg.sv
// Shared types and constants for the BCD count display.
package count_disp_pkg;

  localparam int unsigned BCD_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  typedef enum logic [1:0] {
    DigOnes,
    DigTens,
    DigHundreds
  } dig_idx_e;

  // Segment codes, bit0 = a .. bit6 = g, active high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One-hot digit enable for a digit index
  function automatic logic [2:0] digit_onehot(input dig_idx_e idx);
    logic [2:0] sel;
    unique case (idx)
      DigOnes:     sel = 3'b001;
      DigTens:     sel = 3'b010;
      DigHundreds: sel = 3'b100;
      default:     sel = 3'b001;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment lookup with blanking.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Map digit to segment pattern; blank and non-decimal codes show nothing
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (shift-add-3) driving a multiplexed 3-digit display.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       value_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out,
  output logic [6:0]       seg_out,
  output logic [2:0]       digit_sel
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

  state_e           r_state, w_state_d;
  logic [7:0]       r_value, w_value_d;
  logic [BCD_W-1:0] r_scratch, w_scratch_d;
  logic [2:0]       r_iter, w_iter_d;
  logic [BCD_W-1:0] r_bcd, w_bcd_d;
  logic             r_done, w_done_d;
  logic [BCD_W-1:0] w_adj;
  logic [19:0]      w_shift;

  logic [15:0]      r_refresh;
  dig_idx_e         r_dig;
  logic [6:0]       r_seg;
  logic [2:0]       r_digit_sel;
  logic [3:0]       w_dig_val;
  logic             w_blank;
  logic [6:0]       w_seg;

  // Add-3 correction on each scratch digit, then the combined left shift
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_adj[i*4 +: 4] = (r_scratch[i*4 +: 4] >= 4'd5) ? r_scratch[i*4 +: 4] + 4'd3
                                                       : r_scratch[i*4 +: 4];
    end
    w_shift = {w_adj, r_value} << 1;
  end

  // Conversion FSM next state
  always_comb begin
    w_state_d   = r_state;
    w_value_d   = r_value;
    w_scratch_d = r_scratch;
    w_iter_d    = r_iter;
    w_bcd_d     = r_bcd;
    w_done_d    = 1'b0;
    case (r_state)
      StIdle: begin
        if (load) begin
          w_value_d   = value_in;
          w_scratch_d = '0;
          w_iter_d    = '0;
          w_state_d   = StShift;
        end
      end
      StShift: begin
        w_scratch_d = w_shift[19:8];
        w_value_d   = w_shift[7:0];
        w_iter_d    = r_iter + 3'd1;
        if (r_iter == 3'd7) w_state_d = StLatch;
      end
      StLatch: begin
        w_bcd_d   = r_scratch;
        w_done_d  = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Conversion state registers; frozen while disabled, done forced low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_value   <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else if (ena) begin
      r_state   <= w_state_d;
      r_value   <= w_value_d;
      r_scratch <= w_scratch_d;
      r_iter    <= w_iter_d;
      r_bcd     <= w_bcd_d;
      r_done    <= w_done_d;
    end else begin
      r_done    <= 1'b0;
    end
  end

  // Refresh divider and digit index rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_dig     <= DigOnes;
    end else if (ena) begin
      if (r_refresh == REFRESH_LAST) begin
        r_refresh <= '0;
        case (r_dig)
          DigOnes:     r_dig <= DigTens;
          DigTens:     r_dig <= DigHundreds;
          default:     r_dig <= DigOnes;
        endcase
      end else begin
        r_refresh <= r_refresh + 16'd1;
      end
    end
  end

  // Select the displayed digit from the latched result with leading-zero blanking
  always_comb begin
    w_dig_val = r_bcd[3:0];
    w_blank   = 1'b0;
    case (r_dig)
      DigTens: begin
        w_dig_val = r_bcd[7:4];
        w_blank   = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      DigHundreds: begin
        w_dig_val = r_bcd[11:8];
        w_blank   = (r_bcd[11:8] == 4'd0);
      end
      default: begin
        w_dig_val = r_bcd[3:0];
        w_blank   = 1'b0;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_digit (w_dig_val),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg       <= SEG_0;
      r_digit_sel <= 3'b001;
    end else if (ena) begin
      r_seg       <= w_seg;
      r_digit_sel <= digit_onehot(r_dig);
    end
  end

  assign busy      = (r_state != StIdle);
  assign done      = r_done & ena;
  assign bcd_out   = r_bcd;
  assign seg_out   = r_seg;
  assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display with a BCD result scoreboard.
module tb_count_bcd_display;

  localparam int unsigned RDIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  value_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [6:0]  seg_out;
  logic [2:0]  digit_sel;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];

  count_bcd_display #(.REFRESH_DIV(RDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .value_in  (value_in),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .seg_out   (seg_out),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load pulse, then wait for done and check against the scoreboard
  task automatic do_convert(input int v, input string name);
    int n;
    logic [11:0] exp;
    value_in = 8'(v);
    load = 1'b1;
    exp_q.push_back(to_bcd(v));
    tick();
    load = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles", name, n);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      if (bcd_out !== exp) begin
        n_fail++;
        $display("FAIL %s v=%0d: bcd_out=%h expected %h", name, v, bcd_out, exp);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; load = 1'b0; value_in = '0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: %b exp 0", done); end
    n_checks++; if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL reset bcd: %h exp 000", bcd_out); end
    n_checks++; if (digit_sel !== 3'b001) begin n_fail++; $display("FAIL reset sel: %b exp 001", digit_sel); end
    n_checks++; if (seg_out !== 7'h3F) begin n_fail++; $display("FAIL reset seg: %h exp 3F", seg_out); end
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();
  endtask

  task automatic test_convert_255();
    int n;
    logic [11:0] exp;
    value_in = 8'd255;
    load = 1'b1;
    exp_q.push_back(to_bcd(255));
    tick();  // E0
    load = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 255 busy@E0: %b exp 1", busy); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL 255 E%0d busy/done: %b%b exp 10", k, busy, done);
      end
    end
    tick();  // E9
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL 255 done@E9: %b exp 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 255 busy@E9: %b exp 0", busy); end
    exp = exp_q.pop_front();
    n_checks++; if (bcd_out !== exp) begin n_fail++; $display("FAIL 255 bcd: %h exp %h", bcd_out, exp); end
    tick();  // E10
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL 255 done@E10: %b exp 0", done); end
    n = 0;
    while (digit_sel !== 3'b100 && n < 20) begin tick(); n++; end
    n_checks++;
    if (seg_out !== 7'h5B) begin n_fail++; $display("FAIL 255 hundreds seg: %h exp 5B sel=%b", seg_out, digit_sel); end
  endtask

  task automatic test_refresh();
    logic [2:0] prev;
    logic [2:0] seq [3];
    logic [6:0] segx [3];
    int n;
    seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001;
    segx[0] = 7'h00; segx[1] = 7'h00; segx[2] = 7'h07;
    do_convert(7, "refresh load7");
    prev = digit_sel;
    tick();
    n = 0;
    while (!(digit_sel === 3'b010 && prev === 3'b001) && n < 30) begin
      prev = digit_sel; tick(); n++;
    end
    n_checks++;
    if (n >= 30) begin n_fail++; $display("FAIL refresh sync: sel=%b never 001->010", digit_sel); end
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (digit_sel !== seq[d] || seg_out !== segx[d]) begin
          n_fail++;
          $display("FAIL refresh d%0d c%0d: sel=%b seg=%h exp sel=%b seg=%h",
                   d, c, digit_sel, seg_out, seq[d], segx[d]);
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic [11:0] exp;
    value_in = 8'd100;
    load = 1'b1;
    exp_q.push_back(to_bcd(100));
    tick();  // E0
    load = 1'b0;
    tick(); tick();
    value_in = 8'd200;
    load = 1'b1;
    tick();  // E3, must be ignored
    load = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          n_checks++;
          if (bcd_out !== exp) begin n_fail++; $display("FAIL b2b bcd: %h exp %h", bcd_out, exp); end
        end
      end
    end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL b2b done count: %0d exp 1", ndone); end
    exp_q.delete();
    do_convert(200, "b2b second");
  endtask

  task automatic test_enable_gap();
    int n;
    logic [2:0] sel_hold;
    logic [11:0] exp;
    value_in = 8'd42;
    load = 1'b1;
    exp_q.push_back(to_bcd(42));
    tick();  // E0
    load = 1'b0;
    tick(); tick();
    n = 2;
    ena = 1'b0;
    sel_hold = digit_sel;
    for (int i = 0; i < 5; i++) begin
      tick(); n++;
      n_checks++;
      if (digit_sel !== sel_hold || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL gap frozen %0d: sel=%b done=%b busy=%b exp sel=%b done=0 busy=1",
                 i, digit_sel, done, busy, sel_hold);
      end
    end
    ena = 1'b1;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    n_checks++; if (n != 14) begin n_fail++; $display("FAIL gap done latency: %0d exp 14", n); end
    exp = exp_q.pop_front();
    n_checks++; if (bcd_out !== exp) begin n_fail++; $display("FAIL gap bcd: %h exp %h", bcd_out, exp); end
    tick();
  endtask

  task automatic test_reset_abort();
    int ndone;
    do_convert(123, "abort prior");
    value_in = 8'd77;
    load = 1'b1;
    tick();  // E0
    load = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: %b exp 0", busy); end
    n_checks++; if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL abort bcd: %h exp 000", bcd_out); end
    n_checks++; if (digit_sel !== 3'b001) begin n_fail++; $display("FAIL abort sel: %b exp 001", digit_sel); end
    n_checks++; if (seg_out !== 7'h3F) begin n_fail++; $display("FAIL abort seg: %h exp 3F", seg_out); end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort spurious done: %0d exp 0", ndone); end
    n_checks++; if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL abort bcd kept: %h exp 000", bcd_out); end
    do_convert(58, "after reset");
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) do_convert(v, "exhaustive");
  endtask

  initial begin
    test_reset();
    test_convert_255();
    test_refresh();
    test_back_to_back();
    test_enable_gap();
    test_reset_abort();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1024, clock cycles each digit is displayed (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have port value_in  input  8  unsigned binary count from the upstream counter stage.
REQ-006 SHALL have port load  input  1  request to sample value_in and convert.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; bcd_out updated.
REQ-009 SHALL have port bcd_out  output  12  latched BCD result {hundreds, tens, ones}, 4 bits each.
REQ-010 SHALL have port seg_out  output  7  segments, bit0=a..bit6=g, active high, registered.
REQ-011 SHALL have port digit_sel  output  3  one-hot digit enable, 001=ones, 010=tens, 100=hundreds, registered.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, LATCH; busy = (state != IDLE).
REQ-013 SHALL, in IDLE with ena=1 and load=1 at edge E0, capture value_in, clear 12-bit scratch, clear iteration count, go to SHIFT.
REQ-014 SHALL, in SHIFT, each enabled edge: add 3 to every scratch digit >= 5, then shift {scratch, value} left one bit; after the 8th shift (E8) go to LATCH.
REQ-015 SHALL, in LATCH at edge E9, copy scratch to bcd_out, set done=1 for exactly the cycle E9..E10, return to IDLE.
REQ-016 SHALL ignore load while busy=1; no queuing, no restart.
REQ-017 SHALL produce bcd_out in range 0x000..0x255; digits never exceed 9.
REQ-018 SHALL hold FSM, iteration count, scratch and refresh counter unchanged while ena=0; done SHALL be 0 while ena=0.
REQ-019 SHALL run a refresh counter 0..REFRESH_DIV-1 while ena=1; at terminal count wrap to 0 and advance digit index ones->tens->hundreds->ones.
REQ-020 SHALL register digit_sel and seg_out from current digit index and bcd_out each enabled cycle (one-cycle lag).
REQ-021 SHALL encode digits 0-9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-022 SHALL blank (seg_out=00) hundreds when hundreds=0, and tens when hundreds=0 and tens=0; ones never blanked.
REQ-023 SHALL display bcd_out only (never scratch), so the display is stable during conversion.

Reset
REQ-024 SHALL, on rst_n low, immediately set state=IDLE, busy=0, done=0, bcd_out=000, scratch=0, iteration=0, refresh=0, digit index=ones, digit_sel=001, seg_out=3F.
REQ-025 SHALL abort any conversion on reset without updating bcd_out; first load after rst_n release behaves per REQ-013.

Structure
REQ-026 SHALL place FSM state enum, digit-index type, segment code constants (SEG_0..SEG_9, SEG_BLANK) and the BCD width constant in shared package count_disp_pkg.
REQ-027 SHALL implement BCD-to-segment lookup as combinational sub-module seg7_decode (4-bit digit + blank in, 7-bit segments out).

Verification
REQ-028 SHALL verify: value_in=255, load pulse at E0 -> busy high E0..E9, done high only E9..E10, bcd_out=0x255, hundreds digit seg_out=5B.
REQ-029 SHALL verify: value_in=7, REFRESH_DIV=4 -> digit_sel 001/010/100 each 4 cycles; seg_out 07 on ones, 00 on tens and hundreds.
REQ-030 SHALL verify: load with 100 at E0, load with 200 at E3 -> single done, bcd_out=0x100; subsequent load 200 in IDLE -> bcd_out=0x200.
REQ-031 SHALL verify: load 42, ena=0 for 5 cycles during SHIFT -> done delayed exactly 5 cycles, bcd_out=0x042, digit_sel frozen during gap.
REQ-032 SHALL verify: rst_n low at E4 of a conversion (prior bcd_out=0x123) -> asynchronous busy=0, bcd_out=000, digit_sel=001, seg_out=3F, no done.
REQ-033 SHALL verify: exhaustive value_in 0..255 -> bcd_out equals decimal of value_in for every input.
